// File: rtl/ro_slot_mux.sv
// Time-division readout multiplexer: a gray counter gives channel k a slot each time gray bit k toggles,
// and the selected channel's data is presented on one registered readout bus.
module ro_slot_mux #(
    parameter int NCH  = 8,
    parameter int DW   = 2,
    parameter int MODE = 0
) (
    input  logic                    clk_master,
    input  logic                    rstb,
    input  logic                    en,
    input  logic [NCH-1:0]          ch_mask,
    input  logic [NCH*DW-1:0]       in_data,
    output logic [DW-1:0]           rd_data,
    output logic [$clog2(NCH)-1:0]  rd_ch,
    output logic                    rd_valid,
    output logic                    frame_start,
    output logic [NCH-1:0]          gray_out
);

    localparam int CW    = $clog2(NCH);
    localparam bit DELTA = (MODE != 0);

    logic [NCH-1:0]    cnt_q, cnt_d;
    logic [NCH-1:0]    gray_q, gray_d;
    logic [DW-1:0]     rd_data_q, rd_data_d;
    logic [CW-1:0]     rd_ch_q, rd_ch_d;
    logic              rd_valid_q, rd_valid_d;
    logic              frame_q, frame_d;
    logic [NCH*DW-1:0] last_q, last_d;

    int                slot;
    logic [DW-1:0]     slot_data;
    logic [DW-1:0]     slot_last;
    logic              emit;
    logic [NCH-1:0]    cnt_inc;

    always_comb begin
        // Trailing-ones count of cnt, capped at NCH-1: the lowest zero bit wins.
        slot = NCH - 1;
        for (int i = NCH - 2; i >= 0; i--) begin
            if (!cnt_q[i]) slot = i;
        end
        slot_data = in_data[slot*DW +: DW];
        slot_last = last_q[slot*DW +: DW];
        emit      = ch_mask[slot] && (!DELTA || (slot_data != slot_last));
        cnt_inc   = cnt_q + NCH'(1);

        cnt_d      = cnt_q;
        gray_d     = gray_q;
        rd_data_d  = rd_data_q;
        rd_ch_d    = rd_ch_q;
        rd_valid_d = 1'b0;
        frame_d    = 1'b0;
        last_d     = last_q;
        if (en) begin
            cnt_d      = cnt_inc;
            gray_d     = cnt_inc ^ (cnt_inc >> 1);
            rd_data_d  = slot_data;
            rd_ch_d    = CW'(slot);
            rd_valid_d = emit;
            frame_d    = &cnt_q;
            if (emit) last_d[slot*DW +: DW] = slot_data;
        end
    end

    always_ff @(posedge clk_master) begin
        if (!rstb) begin
            cnt_q      <= '0;
            gray_q     <= '0;
            rd_data_q  <= '0;
            rd_ch_q    <= '0;
            rd_valid_q <= 1'b0;
            frame_q    <= 1'b0;
            last_q     <= '0;
        end else begin
            cnt_q      <= cnt_d;
            gray_q     <= gray_d;
            rd_data_q  <= rd_data_d;
            rd_ch_q    <= rd_ch_d;
            rd_valid_q <= rd_valid_d;
            frame_q    <= frame_d;
            last_q     <= last_d;
        end
    end

    assign rd_data     = rd_data_q;
    assign rd_ch       = rd_ch_q;
    assign rd_valid    = rd_valid_q;
    assign frame_start = frame_q;
    assign gray_out    = gray_q;

endmodule

// File: doc/ro_slot_mux.md
Name: ro_slot_mux

Overview:
- Parametrised time-division readout multiplexer for the cochlea channel array.
- Replaces the per-core gray-bit-gated tri-state readout with a single registered, synchronous N-channel readout bus.
- An internal gray counter assigns channel k its slot on every clk_master cycle in which gray bit k toggles, so slower cores are read at proportionally lower rates.
- Adds a per-channel enable mask, an optional delta (report-on-change) mode, and a frame marker. Sits between the core array and the serial/packet output stage.

Parameters:
- NCH, 8, number of channels (cores); also the gray counter width; NCH >= 2.
- DW, 2, data bits per channel (bit 0 = eve, bit 1 = pol_eve).
- MODE, 0, 0 = emit on every enabled slot; 1 = delta mode, emit only when the channel's data differs from its last emitted value.

Ports:
- clk_master  in  1  master clock; all state updates on its rising edge.
- rstb  in  1  reset, synchronous and active-low.
- en  in  1  counter/readout advance enable.
- ch_mask  in  NCH  per-channel enable; bit k gates channel k.
- in_data  in  NCH*DW  channel data; slice k = in_data[k*DW +: DW].
- rd_data  out  DW  registered readout data.
- rd_ch  out  $clog2(NCH)  channel index of rd_data.
- rd_valid  out  1  rd_data/rd_ch are valid this cycle.
- frame_start  out  1  one-cycle pulse after the counter wraps.
- gray_out  out  NCH  registered gray code of the internal counter.

Behaviour:
- Reset (rstb=0 at a clk_master edge): cnt=0, gray_out=0, rd_data=0, rd_ch=0, rd_valid=0, frame_start=0, all last[k]=0. Reset is synchronous only and overrides en; it applies mid-frame and frame counting restarts at 0.
- Counter:
  - cnt is an NCH-bit binary counter, incremented modulo 2^NCH on each edge with en=1; it holds when en=0.
  - gray_out <= (cnt+1) ^ ((cnt+1)>>1) on advancing edges, so gray_out always equals gray(cnt).
- Slot decode (combinational, from current cnt = c):
  - s(c) = number of trailing ones of c, capped at NCH-1. This equals the index of the gray bit that toggles on this increment.
  - Channel k<NCH-1 is slotted when c mod 2^(k+1) = 2^k-1, i.e. every 2^(k+1) cycles.
  - Channel NCH-1 is slotted at c = 2^(NCH-1)-1 and c = 2^NCH-1, i.e. twice per 2^NCH-cycle frame.
  - Exactly one slot per advancing cycle; no idle slots.
- Emit, on an edge with en=1, with d = in_data slice s(c):
  - rd_ch <= s(c) and rd_data <= d unconditionally.
  - rd_valid <= ch_mask[s] && (MODE==0 || d != last[s]).
  - If that rd_valid term is 1, last[s] <= d. Masked slots never update last.
  - Latency: one clk_master cycle from slot cycle to rd_valid.
- en=0 edge: rd_valid <= 0 and frame_start <= 0; rd_data, rd_ch, cnt, gray_out and last hold.
- frame_start <= 1 on the advancing edge where c = 2^NCH-1 (the wrap), otherwise 0. It coincides with the rd_ch=NCH-1 output of the wrap slot.
- ch_mask and in_data are sampled only on the slot edge. Changes between slots are not reported, and no buffering or overflow accounting exists.
- Delta mode after reset: last=0, so a nonzero first sample is emitted and a zero first sample is not.
- No combinational path from inputs to outputs; all outputs are registered.

Test Plan:
- Slot order (NCH=4, DW=2, MODE=0, mask=4'hF, en=1 from reset release) -> rd_ch over 16 valid cycles = 0,1,0,2,0,1,0,3,0,1,0,2,0,1,0,3. rd_valid=1 throughout. frame_start=1 only with the 16th output, repeating every 16 cycles. gray_out steps 0,1,3,2,6,7,5,4,C,D,F,E,A,B,9,8,0.
- Data capture: in_data = 8'b11_10_01_00 held -> rd_data = 00/01/00/10/00/01/00/11 following the rd_ch order above, each output one cycle after its slot.
- Mask: ch_mask=4'b1010 -> rd_valid=1 only when rd_ch is 1 or 3 (6 of 16 per frame). rd_ch still advances.
- Delta mode (MODE=1): ch0 data constant 2'b01 -> one rd_valid for ch0 after reset, then none. Change ch0 to 2'b10 -> exactly one further ch0 emit at its next slot. Constant 0 on ch2 -> never valid.
- en gating: deassert en for 5 cycles at c=5 -> rd_valid=0 and gray_out frozen at 7 for those cycles. On re-enable, the next rd_ch=1 continues the sequence without skipping or repeating a slot.
- Mid-frame reset: rstb=0 for 1 edge at c=10 -> next cycle all outputs 0 and gray_out=0. After release, the sequence restarts at rd_ch=0. In MODE=1, previously reported values are re-emitted.
